// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one line-wide backing memory port between the icache miss path and
// the dcache miss/writeback path.
//
// Arbitration is round-robin. last_grant resets to icache, so the dcache wins
// the first conflict. Only one transaction is in flight at a time, and its
// response is routed back to the requester that owns it.
//
// Ports
//   clk_i, reset_ni        clock, asynchronous active-low reset
//   ic_req_*               icache line-fill request (valid/ready/addr)
//   ic_rsp_valid_o         one-cycle pulse, fill data on rsp_data_o
//   dc_req_*               dcache request (valid/ready/addr/write/wdata)
//   dc_rsp_valid_o         one-cycle pulse, fill data or write ack
//   rsp_data_o             shared response line, qualified by the rsp valids
//   mem_req_*              latched request toward the memory controller
//   mem_rsp_*              memory response (read data or write ack)
//   timeout_o              sticky flag, set when memory never answered
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,

    input  logic                  ic_req_valid_i,
    output logic                  ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
    output logic                  ic_rsp_valid_o,

    input  logic                  dc_req_valid_i,
    output logic                  dc_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
    input  logic                  dc_req_write_i,
    input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
    output logic                  dc_rsp_valid_o,

    output logic [LINE_WIDTH-1:0] rsp_data_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic                  mem_req_write_o,
    output logic [LINE_WIDTH-1:0] mem_req_wdata_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,

    output logic                  timeout_o
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IC,
        OWN_DC
    } owner_t;

    state_t                state, state_next;
    owner_t                owner, owner_next;
    logic                  last_grant_dc, last_grant_dc_next;
    logic [CNT_WIDTH-1:0]  wait_count, wait_count_next;
    logic                  ic_rsp, ic_rsp_next;
    logic                  dc_rsp, dc_rsp_next;
    logic                  timeout, timeout_next;
    logic [LINE_WIDTH-1:0] rsp_data, rsp_data_next;
    logic [ADDR_WIDTH-1:0] req_addr, req_addr_next;
    logic                  req_write, req_write_next;
    logic [LINE_WIDTH-1:0] req_wdata, req_wdata_next;
    logic                  grant_ic, grant_dc;
    logic                  rsp_busy;
    logic                  finish;

    // State and datapath registers. Reset discards any in-flight request and
    // drops any pending response pulse.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            last_grant_dc <= 1'b0;
            wait_count    <= '0;
            ic_rsp        <= 1'b0;
            dc_rsp        <= 1'b0;
            timeout       <= 1'b0;
            rsp_data      <= '0;
            req_addr      <= '0;
            req_write     <= 1'b0;
            req_wdata     <= '0;
        end else begin
            state         <= state_next;
            owner         <= owner_next;
            last_grant_dc <= last_grant_dc_next;
            wait_count    <= wait_count_next;
            ic_rsp        <= ic_rsp_next;
            dc_rsp        <= dc_rsp_next;
            timeout       <= timeout_next;
            rsp_data      <= rsp_data_next;
            req_addr      <= req_addr_next;
            req_write     <= req_write_next;
            req_wdata     <= req_wdata_next;
        end
    end

    // Next-state, arbitration and response routing.
    always_comb begin
        state_next         = state;
        owner_next         = owner;
        last_grant_dc_next = last_grant_dc;
        wait_count_next    = wait_count;
        ic_rsp_next        = 1'b0;
        dc_rsp_next        = 1'b0;
        timeout_next       = timeout;
        rsp_data_next      = rsp_data;
        req_addr_next      = req_addr;
        req_write_next     = req_write;
        req_wdata_next     = req_wdata;
        grant_ic           = 1'b0;
        grant_dc           = 1'b0;
        finish             = 1'b0;

        // The state is already IDLE while a response pulse is out. Grants are
        // held off during that cycle, so the earliest re-grant is the cycle
        // after the pulse.
        rsp_busy = ic_rsp | dc_rsp;

        case (state)
            IDLE: begin
                if (!rsp_busy) begin
                    // On a conflict, the requester that did not win last time
                    // gets the port.
                    if (dc_req_valid_i && (!ic_req_valid_i || !last_grant_dc)) begin
                        grant_dc = 1'b1;
                    end else if (ic_req_valid_i) begin
                        grant_ic = 1'b1;
                    end
                end
                if (grant_dc) begin
                    req_addr_next      = dc_req_addr_i;
                    req_write_next     = dc_req_write_i;
                    req_wdata_next     = dc_req_wdata_i;
                    owner_next         = OWN_DC;
                    last_grant_dc_next = 1'b1;
                    state_next         = ISSUE;
                end else if (grant_ic) begin
                    // The icache only fills lines, so it never writes.
                    req_addr_next      = ic_req_addr_i;
                    req_write_next     = 1'b0;
                    req_wdata_next     = '0;
                    owner_next         = OWN_IC;
                    last_grant_dc_next = 1'b0;
                    state_next         = ISSUE;
                end
            end

            ISSUE: begin
                // A response in the same cycle as the handshake is ignored.
                if (mem_req_ready_i) begin
                    wait_count_next = '0;
                    state_next      = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    rsp_data_next = mem_rsp_data_i;
                    finish        = 1'b1;
                end else if (wait_count == CNT_LAST) begin
                    // Hand the owner zeroed data so its miss path cannot hang.
                    rsp_data_next = '0;
                    timeout_next  = 1'b1;
                    finish        = 1'b1;
                end else begin
                    wait_count_next = wait_count + CNT_WIDTH'(1);
                end
                if (finish) begin
                    ic_rsp_next     = (owner == OWN_IC);
                    dc_rsp_next     = (owner == OWN_DC);
                    owner_next      = OWN_NONE;
                    wait_count_next = '0;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ic_req_ready_o  = grant_ic;
    assign dc_req_ready_o  = grant_dc;
    assign ic_rsp_valid_o  = ic_rsp;
    assign dc_rsp_valid_o  = dc_rsp;
    assign rsp_data_o      = rsp_data;
    assign mem_req_valid_o = (state == ISSUE);
    assign mem_req_addr_o  = req_addr;
    assign mem_req_write_o = req_write;
    assign mem_req_wdata_o = req_wdata;
    assign timeout_o       = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter. Directed stimulus pushes requester
// traffic, memory behaviour and expected results into queues. A monitor
// compares memory requests and response pulses as they appear.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic [AW-1:0] dc_req_addr;
    logic          dc_req_write;
    logic [LW-1:0] dc_req_wdata;
    logic          dc_rsp_valid;
    logic [LW-1:0] rsp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_write;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_rsp_valid;
    logic [LW-1:0] mem_rsp_data;
    logic          timeout;

    mem_port_arbiter #(
        .ADDR_WIDTH    (AW),
        .LINE_WIDTH    (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .ic_req_valid_i (ic_req_valid),
        .ic_req_ready_o (ic_req_ready),
        .ic_req_addr_i  (ic_req_addr),
        .ic_rsp_valid_o (ic_rsp_valid),
        .dc_req_valid_i (dc_req_valid),
        .dc_req_ready_o (dc_req_ready),
        .dc_req_addr_i  (dc_req_addr),
        .dc_req_write_i (dc_req_write),
        .dc_req_wdata_i (dc_req_wdata),
        .dc_rsp_valid_o (dc_rsp_valid),
        .rsp_data_o     (rsp_data),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o (mem_req_addr),
        .mem_req_write_o(mem_req_write),
        .mem_req_wdata_o(mem_req_wdata),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i (mem_rsp_data),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [LW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          is_dc;
        logic [LW-1:0] data;
        int            latency;
    } rsp_exp_t;

    typedef struct {
        int            rdy_dly;
        int            rsp_dly;
        logic          respond;
        logic [LW-1:0] data;
    } mem_beh_t;

    req_t     ic_q[$];
    req_t     dc_q[$];
    req_t     exp_mem_q[$];
    rsp_exp_t exp_rsp_q[$];
    mem_beh_t mem_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int hs_cyc     = 0;

    task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                               input logic [LW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s", name);
    endtask

    // Queue one request. If expect_rsp is set, also queue the owner pulse the
    // scoreboard should see. Callers push in the expected grant order.
    task automatic applyStimulus(input logic is_dc, input logic [AW-1:0] addr,
                                 input logic write, input logic [LW-1:0] wdata,
                                 input int rdy_dly, input int rsp_dly,
                                 input logic respond, input logic [LW-1:0] data,
                                 input logic expect_rsp, input int latency);
        req_t     r;
        mem_beh_t b;
        rsp_exp_t e;
        r.addr  = addr;
        r.write = write;
        r.wdata = wdata;
        if (is_dc) dc_q.push_back(r);
        else       ic_q.push_back(r);
        exp_mem_q.push_back(r);
        b.rdy_dly = rdy_dly;
        b.rsp_dly = rsp_dly;
        b.respond = respond;
        b.data    = data;
        mem_q.push_back(b);
        if (expect_rsp) begin
            e.is_dc   = is_dc;
            e.data    = respond ? data : '0;
            e.latency = latency;
            exp_rsp_q.push_back(e);
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while ((exp_mem_q.size() != 0 || exp_rsp_q.size() != 0 || ic_q.size() != 0 ||
                dc_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_mem_q.size() != 0 || exp_rsp_q.size() != 0 || mem_q.size() != 0)
            reportFail({name, "_timeout"});
        repeat (2) @(negedge clk);
    endtask

    // icache requester: holds valid until accepted, then presents the next request.
    initial begin : ic_driver
        logic taken;
        ic_req_valid = 1'b0;
        ic_req_addr  = '0;
        forever begin
            @(negedge clk);
            taken = ic_req_valid && ic_req_ready;
            @(posedge clk);
            #1;
            if (taken) ic_req_valid = 1'b0;
            if (!ic_req_valid && ic_q.size() != 0) begin
                ic_req_addr  = ic_q[0].addr;
                void'(ic_q.pop_front());
                ic_req_valid = 1'b1;
            end
        end
    end

    // dcache requester: same handshake behaviour as the icache requester.
    initial begin : dc_driver
        logic taken;
        req_t r;
        dc_req_valid = 1'b0;
        dc_req_addr  = '0;
        dc_req_write = 1'b0;
        dc_req_wdata = '0;
        forever begin
            @(negedge clk);
            taken = dc_req_valid && dc_req_ready;
            @(posedge clk);
            #1;
            if (taken) dc_req_valid = 1'b0;
            if (!dc_req_valid && dc_q.size() != 0) begin
                r = dc_q.pop_front();
                dc_req_addr  = r.addr;
                dc_req_write = r.write;
                dc_req_wdata = r.wdata;
                dc_req_valid = 1'b1;
            end
        end
    end

    // Memory model: stalls ready for rdy_dly cycles. It answers rsp_dly cycles
    // after the handshake, or never if respond is clear.
    initial begin : mem_model
        mem_beh_t b;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid) begin
                if (mem_q.size() == 0) begin
                    reportFail("mem_model_no_behaviour");
                    b.rdy_dly = 0;
                    b.rsp_dly = 1;
                    b.respond = 1'b0;
                    b.data    = '0;
                end else begin
                    b = mem_q[0];
                end
                repeat (b.rdy_dly) begin
                    @(posedge clk);
                    #1;
                end
                mem_req_ready = 1'b1;
                @(posedge clk);
                #1;
                mem_req_ready = 1'b0;
                if (mem_q.size() != 0) void'(mem_q.pop_front());
                if (b.respond) begin
                    repeat (b.rsp_dly - 1) begin
                        @(posedge clk);
                        #1;
                    end
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = b.data;
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = '0;
                end
            end
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin : monitor
        logic     accept_seen;
        rsp_exp_t e;
        accept_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (accept_seen)
                checkOutput("req_to_mem_valid_latency", LW'(mem_req_valid), LW'(1));
            accept_seen = (ic_req_valid && ic_req_ready) || (dc_req_valid && dc_req_ready);
            if (ic_req_valid && dc_req_valid && (ic_req_ready || dc_req_ready))
                checkOutput("ready_onehot", LW'(ic_req_ready && dc_req_ready), LW'(0));

            if (mem_req_valid) begin
                if (mem_rsp_valid) reportFail("mem_rsp_during_issue");
                if (exp_mem_q.size() == 0) begin
                    reportFail("unexpected_mem_req");
                end else begin
                    checkOutput("mem_addr",  LW'(mem_req_addr),  LW'(exp_mem_q[0].addr));
                    checkOutput("mem_write", LW'(mem_req_write), LW'(exp_mem_q[0].write));
                    checkOutput("mem_wdata", mem_req_wdata, exp_mem_q[0].wdata);
                    if (mem_req_ready) begin
                        void'(exp_mem_q.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end

            if (ic_rsp_valid || dc_rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    reportFail("unexpected_rsp_pulse");
                end else begin
                    e = exp_rsp_q.pop_front();
                    checkOutput("ic_rsp_valid", LW'(ic_rsp_valid), LW'(!e.is_dc));
                    checkOutput("dc_rsp_valid", LW'(dc_rsp_valid), LW'(e.is_dc));
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_latency", LW'(cyc - hs_cyc), LW'(e.latency));
                    checkOutput("ready_during_rsp", LW'({ic_req_ready, dc_req_ready}), LW'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        logic [LW-1:0] d1, d2, wb, ck;
        d1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        d2 = 128'h11112222_33334444_55556666_77778888;
        wb = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
        ck = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_valid", LW'(mem_req_valid), LW'(0));
        checkOutput("reset_mem_addr",  LW'(mem_req_addr),  LW'(0));
        checkOutput("reset_mem_wdata", mem_req_wdata, '0);
        checkOutput("reset_rsp_data",  rsp_data, '0);
        checkOutput("reset_timeout",   LW'(timeout), LW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single icache fill");
        applyStimulus(1'b0, 32'h0000_1000, 1'b0, '0, 2, 3, 1'b1, d1, 1'b1, 4);
        waitDone("ic_fill", 100);

        $display("[TB] simultaneous requests, dcache first");
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, '0, 0, 1, 1'b1, d2, 1'b1, 2);
        applyStimulus(1'b0, 32'h0000_0100, 1'b0, '0, 1, 2, 1'b1, d1, 1'b1, 3);
        waitDone("conflict", 100);

        $display("[TB] three rounds of contention");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_2000 + 32'(i * 64), 1'b0, '0, i, 1, 1'b1, d2 ^ LW'(i), 1'b1, 2);
            applyStimulus(1'b0, 32'h0000_3000 + 32'(i * 64), 1'b0, '0, 0, 2, 1'b1, d1 ^ LW'(i), 1'b1, 3);
        end
        waitDone("contention", 300);

        $display("[TB] dcache writeback with stalled memory");
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, wb, 5, 2, 1'b1, '0, 1'b1, 3);
        waitDone("writeback", 100);
        checkOutput("timeout_before", LW'(timeout), LW'(0));

        $display("[TB] memory never responds");
        applyStimulus(1'b0, 32'h0000_5000, 1'b0, '0, 0, 1, 1'b0, d1, 1'b1, TO + 1);
        waitDone("timeout_case", 100);
        checkOutput("timeout_set", LW'(timeout), LW'(1));
        applyStimulus(1'b1, 32'h0000_6000, 1'b0, '0, 0, 1, 1'b1, ck, 1'b1, 2);
        waitDone("after_timeout", 100);
        checkOutput("timeout_sticky", LW'(timeout), LW'(1));

        $display("[TB] reset during WAIT_RSP");
        applyStimulus(1'b1, 32'h0000_7000, 1'b0, '0, 0, 10, 1'b1, d2, 1'b0, 0);
        begin
            int n = 0;
            while (exp_mem_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (exp_mem_q.size() != 0) reportFail("reset_case_issue_timeout");
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_mem_valid", LW'(mem_req_valid), LW'(0));
        checkOutput("midrst_mem_addr",  LW'(mem_req_addr),  LW'(0));
        checkOutput("midrst_rsp_valid", LW'({ic_rsp_valid, dc_rsp_valid}), LW'(0));
        checkOutput("midrst_timeout",   LW'(timeout), LW'(0));
        checkOutput("midrst_rsp_data",  rsp_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("midrst_no_pending_rsp", LW'(exp_rsp_q.size()), LW'(0));
        checkOutput("midrst_mem_model_idle", LW'(mem_q.size()), LW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single line-wide backing memory port between the instruction-cache miss path and the data-cache miss/writeback path.
- Round-robin arbitration with a dcache tie-break on the first conflict.
- One outstanding transaction at a time; the response is routed back to the owning requester.
- Sits between icache/dcache fill logic and the memory controller.

Parameters:
- ADDR_WIDTH, 32, byte address width of line requests.
- LINE_WIDTH, 128, cache line width in bits (data and wdata buses).
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_RSP before the timeout error is flagged.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- ic_req_valid_i  in  1  icache line-fill request.
- ic_req_ready_o  out  1  icache request accepted this cycle.
- ic_req_addr_i  in  ADDR_WIDTH  icache line address.
- ic_rsp_valid_o  out  1  icache fill data valid (1-cycle pulse).
- dc_req_valid_i  in  1  dcache request.
- dc_req_ready_o  out  1  dcache request accepted this cycle.
- dc_req_addr_i  in  ADDR_WIDTH  dcache line address.
- dc_req_write_i  in  1  1 = writeback, 0 = fill.
- dc_req_wdata_i  in  LINE_WIDTH  writeback line.
- dc_rsp_valid_o  out  1  dcache fill/write-ack valid (1-cycle pulse).
- rsp_data_o  out  LINE_WIDTH  shared response line, qualified by ic_/dc_rsp_valid_o.
- mem_req_valid_o  out  1  request to memory.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  ADDR_WIDTH  latched address.
- mem_req_write_o  out  1  latched write flag.
- mem_req_wdata_o  out  LINE_WIDTH  latched write line.
- mem_rsp_valid_i  in  1  memory response (read data or write ack).
- mem_rsp_data_i  in  LINE_WIDTH  read data.
- timeout_o  out  1  sticky; set on WAIT_RSP timeout, cleared only by reset.

Behaviour:
- Reset values:
  - State IDLE; owner = none; last_grant = IC, so dcache wins the first conflict.
  - All valid/ready outputs 0; mem_req_addr_o, mem_req_wdata_o, mem_req_write_o, rsp_data_o all 0.
  - Timeout counter 0; timeout_o 0.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - ic_req_ready_o / dc_req_ready_o are combinational; at most one is high, and only for the winner among the asserted valids.
  - Winner rule: sole requester wins. If both request, the requester not equal to last_grant wins.
  - On acceptance: latch addr/write/wdata (icache write forced to 0), set owner, update last_grant, go to ISSUE.
  - Request-to-mem_req_valid_o latency is 1 cycle.
- ISSUE:
  - mem_req_valid_o = 1; addr/write/wdata held stable until mem_req_ready_i.
  - On handshake, go to WAIT_RSP; the timeout counter clears.
  - mem_rsp_valid_i is not accepted in ISSUE. A response arriving in the same cycle as the handshake is ignored; memory must respond at least 1 cycle after acceptance.
- WAIT_RSP:
  - Counter increments each cycle.
  - On mem_rsp_valid_i: register rsp_data_o = mem_rsp_data_i and pulse the owner's rsp_valid for exactly one cycle, the cycle after mem_rsp_valid_i. Return to IDLE in that same cycle.
  - Both ready outputs are low during the response pulse.
  - If the counter reaches TIMEOUT_CYCLES-1 without a response: set timeout_o, pulse the owner's rsp_valid with rsp_data_o = 0, and return to IDLE. This keeps the pipeline from deadlocking.
- Requesters must hold valid/addr/wdata stable until ready. Deasserting valid before ready is legal in IDLE; nothing is latched.
- Ready outputs are 0 in ISSUE, WAIT_RSP and the response cycle; no new request is accepted until IDLE.
- Back-to-back: the earliest re-grant is the cycle after the response pulse.
- Alternation: with both requesters continuously valid, grants alternate DC, IC, DC, IC ...
- mem_rsp_valid_i in IDLE or ISSUE is ignored, with no state change. The bench asserts that it never occurs.
- Reset mid-transaction: immediate return to IDLE; all pulses are dropped; the latched request is discarded.
- Widths: the counter is $clog2(TIMEOUT_CYCLES)+1 bits and never wraps.

Test Plan:
- Single icache fill: ic_req addr 0x0000_1000, mem ready after 2 cycles, rsp data 0xDEADBEEF_... after 3 cycles -> mem_req_addr_o = 0x1000, write 0; ic_rsp_valid_o one-cycle pulse with the data; dc_rsp_valid_o stays 0.
- Simultaneous requests after reset, ic 0x100 and dc 0x200 -> dcache granted first (mem addr 0x200), then icache (0x100).
- Continuous 3-round contention -> grant sequence DC, IC, DC, IC, DC, IC.
- dcache writeback addr 0x40, wdata 0xA5A5..., mem_req_ready_i held low 5 cycles -> addr, wdata and write = 1 stable all 5 cycles; write ack pulses dc_rsp_valid_o once.
- No response with TIMEOUT_CYCLES = 16 -> after 16 WAIT_RSP cycles timeout_o = 1 (sticky), owner rsp pulse with data 0, FSM back to IDLE and accepting requests.
- reset_ni asserted in WAIT_RSP -> outputs at reset values immediately; a later mem_rsp_valid_i produces no rsp pulse.
